// File: rtl/accum_alu_seq_if.sv
// Command/result bundle for accum_alu_seq.
// The master drives commands; the slave returns the accumulator and status.
interface accum_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand_p;
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic [1:0]       error;
  logic             busy;

  modport master (
    output in_valid,
    output opcode,
    output operand_p,
    output operand_q,
    input  in_ready,
    input  result,
    input  out_valid,
    input  error,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  opcode,
    input  operand_p,
    input  operand_q,
    output in_ready,
    output result,
    output out_valid,
    output error,
    output busy
  );
endinterface

// File: rtl/accum_alu_seq.sv
// Multi-cycle accumulator ALU: 1-cycle add/sub/mul/load/clear, iterative exp/div.
// Define ALU_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module accum_alu_seq #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  accum_alu_seq_if.slave io
);

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int W2 = 2 * WIDTH;
  localparam int CW = ($clog2(WIDTH + 1) > EXP_W) ?
                      $clog2(WIDTH + 1) : EXP_W;

  localparam logic [1:0] E_OK  = 2'b00;
  localparam logic [1:0] E_OVF = 2'b01;
  localparam logic [1:0] E_DZ  = 2'b10;
  localparam logic [1:0] E_ILL = 2'b11;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_CLR = 4'b1100;
  localparam logic [3:0] OP_LD  = 4'b1101;
  localparam logic [3:0] OP_EXP = 4'b1111;

  localparam logic [WIDTH-1:0] MAXV = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXP,
    S_DIV,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       err_q, err_d;
  // opb: divisor or exp base; wrk: dividend/quotient or running power
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic [W2-1:0]    mprod;
  logic [W2-1:0]    eprod;
  logic [WIDTH:0]   rsh;
  logic             qbit;
  logic [EXP_W-1:0] qexp;
  logic             unused_opq;

  assign sum   = {1'b0, acc_q} + {1'b0, io.operand_p};
  assign mprod = W2'(acc_q) * W2'(io.operand_p);
  assign eprod = W2'(wrk_q) * W2'(opb_q);
  assign rsh   = {rem_q, wrk_q[WIDTH-1]};
  assign qbit  = (rsh >= {1'b0, opb_q});
  assign qexp  = io.operand_q[EXP_W-1:0];
  assign unused_opq = ^io.operand_q[WIDTH-1:EXP_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    opb_d   = opb_q;
    wrk_d   = wrk_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          state_d = S_DONE;
          err_d   = E_OK;
          case (io.opcode)
            OP_ADD: begin
              acc_d = sum[WIDTH-1:0];
              if (sum[WIDTH]) begin
                err_d = E_OVF;
                if (SAT) acc_d = MAXV;
              end
            end
            OP_SUB: begin
              acc_d = acc_q - io.operand_p;
              if (acc_q < io.operand_p) begin
                err_d = E_OVF;
                if (SAT) acc_d = '0;
              end
            end
            OP_MUL: begin
              acc_d = mprod[WIDTH-1:0];
              if (|mprod[W2-1:WIDTH]) begin
                err_d = E_OVF;
                if (SAT) acc_d = MAXV;
              end
            end
            OP_DIV: begin
              if (io.operand_p == '0) begin
                err_d = E_DZ;
              end else begin
                state_d = S_DIV;
                wrk_d   = acc_q;
                opb_d   = io.operand_p;
                rem_d   = '0;
                cnt_d   = CW'(WIDTH);
              end
            end
            OP_CLR: acc_d = '0;
            OP_LD:  acc_d = io.operand_p;
            OP_EXP: begin
              if (qexp == '0) begin
                acc_d = WIDTH'(1);
              end else begin
                state_d = S_EXP;
                wrk_d   = WIDTH'(1);
                opb_d   = io.operand_p;
                cnt_d   = CW'(qexp);
                ovf_d   = 1'b0;
              end
            end
            default: err_d = E_ILL;
          endcase
        end
      end
      S_EXP: begin
        cnt_d = cnt_q - CW'(1);
        // once saturated the power is pinned; only the counter keeps running
        if (!(SAT && ovf_q)) begin
          wrk_d = eprod[WIDTH-1:0];
          if (|eprod[W2-1:WIDTH]) begin
            ovf_d = 1'b1;
            if (SAT) wrk_d = MAXV;
          end
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          acc_d   = wrk_d;
          err_d   = ovf_d ? E_OVF : E_OK;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q - CW'(1);
        rem_d = qbit ? (rsh[WIDTH-1:0] - opb_q) : rsh[WIDTH-1:0];
        wrk_d = {wrk_q[WIDTH-2:0], qbit};
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          acc_d   = wrk_d;
          err_d   = E_OK;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      err_q   <= E_OK;
      opb_q   <= '0;
      wrk_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      opb_q   <= opb_d;
      wrk_q   <= wrk_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.busy      = (state_q == S_EXP) || (state_q == S_DIV);
  assign io.out_valid = (state_q == S_DONE);
  assign io.result    = acc_q;
  assign io.error     = err_q;

endmodule

// File: tb/tb_accum_alu_seq.sv
// Randomised self-checking bench for accum_alu_seq.
// Expectations come from an arithmetic reference model of the accumulator.
module tb_accum_alu_seq;
  localparam int W = 32;

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  accum_alu_seq_if #(.WIDTH(W)) bus ();

  accum_alu_seq #(.WIDTH(W), .EXP_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] acc_m = '0;

  task automatic model(input logic [3:0] op, input logic [W-1:0] p,
                       input logic [W-1:0] q, output logic [W-1:0] a,
                       output logic [1:0] e, output int lat);
    logic [63:0] f;
    logic [W-1:0] v;
    int qq;
    bit ovf;
    a = acc_m;
    e = 2'b00;
    lat = 1;
    case (op)
      4'd0: begin
        f = 64'(acc_m) + 64'(p);
        a = f[W-1:0];
        if (f >= 64'h1_0000_0000) begin
          e = 2'b01;
          if (SAT) a = '1;
        end
      end
      4'd1: begin
        a = acc_m - p;
        if (acc_m < p) begin
          e = 2'b01;
          if (SAT) a = '0;
        end
      end
      4'd2: begin
        f = 64'(acc_m) * 64'(p);
        a = f[W-1:0];
        if (f >= 64'h1_0000_0000) begin
          e = 2'b01;
          if (SAT) a = '1;
        end
      end
      4'd3: begin
        if (p == 0) e = 2'b10;
        else begin
          a = acc_m / p;
          lat = W + 1;
        end
      end
      4'd12: a = '0;
      4'd13: a = p;
      4'd15: begin
        qq = int'(q % 32);
        v = 1;
        ovf = 0;
        for (int i = 0; i < qq; i++) begin
          f = 64'(v) * 64'(p);
          if (f >= 64'h1_0000_0000) ovf = 1;
          v = f[W-1:0];
        end
        if (ovf) begin
          e = 2'b01;
          if (SAT) v = '1;
        end
        a = v;
        lat = qq + 1;
      end
      default: e = 2'b11;
    endcase
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] p,
                       input logic [W-1:0] q, input bit hold,
                       input string tag);
    logic [W-1:0] ea;
    logic [1:0] ee;
    int el;
    int n;
    int g;
    model(op, p, q, ea, ee, el);
    g = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_wait: in_ready=%b want 1", tag, bus.in_ready);
    end
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.operand_p = p;
    bus.operand_q = q;
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      vectors++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s busy_phase: busy=%b in_ready=%b want 1/0",
                 tag, bus.busy, bus.in_ready);
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (n !== el) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", tag, n, el);
    end
    vectors++;
    if (bus.result !== ea) begin
      miscompares++;
      $display("FAIL %s result: got %h want %h", tag, bus.result, ea);
    end
    vectors++;
    if (bus.error !== ee) begin
      miscompares++;
      $display("FAIL %s error: got %b want %b", tag, bus.error, ee);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s pulse_end: out_valid=%b in_ready=%b want 0/1",
               tag, bus.out_valid, bus.in_ready);
    end
    acc_m = ea;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.operand_p = '0;
    bus.operand_q = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.result !== '0 || bus.error !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_data: result=%h error=%b want 0/00",
               bus.result, bus.error);
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ov=%b rdy=%b busy=%b want 0/1/0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    acc_m = '0;
  endtask

  task automatic test_directed();
    do_op(4'b1100, 32'd0, 32'd0, 0, "clear");
    do_op(4'b1111, 32'd35, 32'd2, 0, "exp35_2");
    vectors++;
    if (bus.result !== 32'd1225) begin
      miscompares++;
      $display("FAIL exp_const: got %0d want 1225", bus.result);
    end
    do_op(4'b0010, 32'd314, 32'd0, 0, "mul314");
    vectors++;
    if (bus.result !== 32'd384650) begin
      miscompares++;
      $display("FAIL mul_const: got %0d want 384650", bus.result);
    end
    do_op(4'b0011, 32'd100, 32'd0, 0, "div100");
    vectors++;
    if (bus.result !== 32'd3846) begin
      miscompares++;
      $display("FAIL div_const: got %0d want 3846", bus.result);
    end
    do_op(4'b0011, 32'd0, 32'd0, 0, "div0");
    do_op(4'b0111, 32'd5, 32'd0, 0, "illegal");
    do_op(4'b1101, 32'hFFFF_FFFF, 32'd0, 0, "load_max");
    do_op(4'b0000, 32'd2, 32'd0, 0, "add_ovf");
    do_op(4'b1101, 32'd3, 32'd0, 0, "load3");
    do_op(4'b0001, 32'd5, 32'd0, 0, "sub_borrow");
    do_op(4'b1111, 32'd0, 32'd0, 0, "exp_q0");
    do_op(4'b1111, 32'd2, 32'd40, 1, "exp_hold");
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd256) begin
      miscompares++;
      $display("FAIL hold_ignored: ov=%b result=%0d want 0/256",
               bus.out_valid, bus.result);
    end
    do_op(4'b1111, 32'd70000, 32'd3, 0, "exp_ovf");
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    do_op(4'b1101, 32'd123456, 32'd0, 0, "load_pre");
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.opcode    = 4'b0011;
    bus.operand_p = 32'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.result !== '0 || bus.in_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_div_reset: res=%h rdy=%b busy=%b ov=%b want 0/1/0/0",
               bus.result, bus.in_ready, bus.busy, bus.out_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc_m = '0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_quiet: pulses=%0d rdy=%b want 0/1",
               pulses, bus.in_ready);
    end
  endtask

  task automatic test_random();
    logic [3:0] pool [16];
    logic [3:0] op;
    logic [W-1:0] p;
    logic [W-1:0] q;
    pool = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3,
             4'd12, 4'd13, 4'd13, 4'd15, 4'd15, 4'd7, 4'd9, 4'd14};
    for (int i = 0; i < 60; i++) begin
      op = pool[$urandom_range(0, 15)];
      p = $urandom;
      if (op == 4'd2 || op == 4'd15) p = $urandom_range(0, 70000);
      if (op == 4'd3 && $urandom_range(0, 7) == 0) p = '0;
      q = $urandom;
      do_op(op, p, q, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    do_op(4'b1101, 32'd10, 32'd0, 0, "b2b_load");
    do_op(4'b0000, 32'd20, 32'd0, 0, "b2b_add");
    do_op(4'b0010, 32'd3, 32'd0, 0, "b2b_mul");
    do_op(4'b0001, 32'd90, 32'd0, 0, "b2b_sub");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    do_op(4'b0000, 32'd9, 32'd0, 0, "after_reset_add");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
